store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_if.sv | 29 ++
 rtl/store_buffer.sv | 100 ++++++++++
 tb/tb_store_buffer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// Core/RAM-facing signal bundle of the store buffer.
// The master side is the core plus data RAM; the slave side is the buffer itself.
interface store_buffer_if #(
  parameter int DEPTH = 4
);
  logic                     MemWrite;
  logic [31:0]              DataAdr;
  logic [31:0]              WriteData;
  logic                     Flush;
  logic [31:0]              ReadData;
  logic                     Stall;
  logic                     mem_we;
  logic [31:0]              mem_addr;
  logic [31:0]              mem_wdata;
  logic                     mem_ready;
  logic [31:0]              mem_rdata;
  logic                     FlushDone;
  logic [$clog2(DEPTH):0]   Count;

  modport master (
    output MemWrite, DataAdr, WriteData, Flush, mem_ready, mem_rdata,
    input  ReadData, Stall, mem_we, mem_addr, mem_wdata, FlushDone, Count
  );

  modport slave (
    input  MemWrite, DataAdr, WriteData, Flush, mem_ready, mem_rdata,
    output ReadData, Stall, mem_we, mem_addr, mem_wdata, FlushDone, Count
  );
endinterface

// File: rtl/store_buffer.sv
// In-order store FIFO between core and data RAM, with youngest-match load
// forwarding and a RUN/FLUSH/DONE drain sequencer.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [29:0]   r_addr [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [PW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;

  logic          w_full, w_empty, w_stall, w_push, w_pop;
  logic          w_fwd_hit;
  logic [31:0]   w_fwd_data;
  logic [PW-1:0] w_idx;
  logic          w_unused;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  // A full buffer refuses the store even if the head drains this same edge.
  assign w_stall  = bus.MemWrite & (w_full | (r_state != RUN));
  assign w_push   = bus.MemWrite & ~w_stall;
  assign w_pop    = ~w_empty & bus.mem_ready;
  assign w_unused = ^bus.DataAdr[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_addr[r_tail] <= bus.DataAdr[31:2];
        r_data[r_tail] <= bus.WriteData;
        r_tail         <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Walk oldest to youngest so the last valid match wins.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    w_idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PW'(i);
      if ((CW'(i) < r_count) && (r_addr[w_idx] == bus.DataAdr[31:2])) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_data[w_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RUN:     if (bus.Flush) w_state_nxt = FLUSH;
      FLUSH:   if (w_empty)   w_state_nxt = DONE;
      DONE:    w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  assign bus.Stall     = w_stall;
  assign bus.mem_we    = ~w_empty;
  assign bus.mem_addr  = w_empty ? '0 : {r_addr[r_head], 2'b00};
  assign bus.mem_wdata = w_empty ? '0 : r_data[r_head];
  assign bus.ReadData  = w_fwd_hit ? w_fwd_data : bus.mem_rdata;
  assign bus.FlushDone = (r_state == DONE);
  assign bus.Count     = r_count;
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed vector table, hand-written flush/reset
// sequences, and randomized traffic checked against a queue-based model.
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  store_buffer_if #(.DEPTH(DEPTH)) bus();
  store_buffer #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        mw;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        fl;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_stall;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [31:0] e_rd;
    int          e_cnt;
    logic        e_fd;
  } vec_t;

  vec_t tbl [20];

  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  int   m_mode;  // 0 = RUN, 1 = FLUSH, 2 = DONE

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic stall, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rd, input int cnt, input logic fd);
    chk({tag, " Stall"},     32'(bus.Stall),     32'(stall));
    chk({tag, " mem_we"},    32'(bus.mem_we),    32'(we));
    chk({tag, " mem_addr"},  bus.mem_addr,       addr);
    chk({tag, " mem_wdata"}, bus.mem_wdata,      wdata);
    chk({tag, " ReadData"},  bus.ReadData,       rd);
    chk({tag, " Count"},     32'(bus.Count),     32'(cnt));
    chk({tag, " FlushDone"}, 32'(bus.FlushDone), 32'(fd));
  endtask

  task automatic drive(input logic mw, input logic [31:0] adr, input logic [31:0] wd,
                       input logic fl, input logic rdy, input logic [31:0] rdata);
    bus.MemWrite  = mw;
    bus.DataAdr   = adr;
    bus.WriteData = wd;
    bus.Flush     = fl;
    bus.mem_ready = rdy;
    bus.mem_rdata = rdata;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sv(input int k, input logic mw, input logic [31:0] adr, input logic [31:0] wd,
                    input logic fl, input logic rdy, input logic [31:0] rdata,
                    input logic st, input logic we, input logic [31:0] ea,
                    input logic [31:0] ew, input logic [31:0] er, input int ec, input logic ef);
    tbl[k].mw = mw;      tbl[k].adr = adr;    tbl[k].wd = wd;
    tbl[k].fl = fl;      tbl[k].rdy = rdy;    tbl[k].rdata = rdata;
    tbl[k].e_stall = st; tbl[k].e_we = we;    tbl[k].e_addr = ea;
    tbl[k].e_wdata = ew; tbl[k].e_rd = er;    tbl[k].e_cnt = ec;
    tbl[k].e_fd = ef;
  endtask

  initial begin
    logic        r_mw, r_fl, r_rdy;
    logic [31:0] r_adr, r_wd, r_rdata;
    logic        e_stall, e_we;
    logic [31:0] e_addr, e_wdata, e_rd;
    int          sz;

    // Expected values are the pre-edge combinational outputs for each row.
    sv( 0, 1'b1, 32'd100,  32'd25, 1'b0, 1'b1, 32'h0,    1'b0, 1'b0, 32'd0,    32'd0,  32'd0,    0, 1'b0);
    sv( 1, 1'b0, 32'd100,  32'd0,  1'b0, 1'b1, 32'h55,   1'b0, 1'b1, 32'd100,  32'd25, 32'd25,   1, 1'b0);
    sv( 2, 1'b0, 32'd0,    32'd0,  1'b0, 1'b0, 32'h77,   1'b0, 1'b0, 32'd0,    32'd0,  32'h77,   0, 1'b0);
    sv( 3, 1'b1, 32'h10,   32'd1,  1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 32'd0,    32'd0,  32'd0,    0, 1'b0);
    sv( 4, 1'b1, 32'h14,   32'd2,  1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 32'h10,   32'd1,  32'd0,    1, 1'b0);
    sv( 5, 1'b1, 32'h18,   32'd3,  1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 32'h10,   32'd1,  32'd0,    2, 1'b0);
    sv( 6, 1'b1, 32'h1C,   32'd4,  1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 32'h10,   32'd1,  32'd0,    3, 1'b0);
    sv( 7, 1'b1, 32'h20,   32'd5,  1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 32'h10,   32'd1,  32'd0,    4, 1'b0);
    sv( 8, 1'b1, 32'h20,   32'd5,  1'b0, 1'b1, 32'h0,    1'b1, 1'b1, 32'h10,   32'd1,  32'd0,    4, 1'b0);
    sv( 9, 1'b1, 32'h20,   32'd5,  1'b0, 1'b1, 32'h0,    1'b0, 1'b1, 32'h14,   32'd2,  32'd0,    3, 1'b0);
    sv(10, 1'b0, 32'h1C,   32'd0,  1'b0, 1'b1, 32'h99,   1'b0, 1'b1, 32'h18,   32'd3,  32'd4,    3, 1'b0);
    sv(11, 1'b0, 32'h0,    32'd0,  1'b0, 1'b1, 32'h0,    1'b0, 1'b1, 32'h1C,   32'd4,  32'd0,    2, 1'b0);
    sv(12, 1'b0, 32'h20,   32'd0,  1'b0, 1'b1, 32'h0,    1'b0, 1'b1, 32'h20,   32'd5,  32'd5,    1, 1'b0);
    sv(13, 1'b1, 32'd96,   32'd7,  1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 32'd0,    32'd0,  32'd0,    0, 1'b0);
    sv(14, 1'b1, 32'd96,   32'd9,  1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 32'd96,   32'd7,  32'd7,    1, 1'b0);
    sv(15, 1'b0, 32'd96,   32'd0,  1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 32'd96,   32'd7,  32'd9,    2, 1'b0);
    sv(16, 1'b0, 32'd104,  32'd0,  1'b0, 1'b0, 32'hABCD, 1'b0, 1'b1, 32'd96,   32'd7,  32'hABCD, 2, 1'b0);
    sv(17, 1'b0, 32'd96,   32'd0,  1'b0, 1'b1, 32'h0,    1'b0, 1'b1, 32'd96,   32'd7,  32'd9,    2, 1'b0);
    sv(18, 1'b0, 32'd0,    32'd0,  1'b0, 1'b1, 32'h0,    1'b0, 1'b1, 32'd96,   32'd9,  32'd0,    1, 1'b0);
    sv(19, 1'b0, 32'd0,    32'd0,  1'b0, 1'b0, 32'h1234, 1'b0, 1'b0, 32'd0,    32'd0,  32'h1234, 0, 1'b0);

    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    reset = 1'b1;
    #1 reset = 1'b0;
    #11;
    chk_all("reset", 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 0, 1'b0);
    reset = 1'b1;
    cyc();

    // Directed vectors
    for (int k = 0; k < 20; k++) begin
      drive(tbl[k].mw, tbl[k].adr, tbl[k].wd, tbl[k].fl, tbl[k].rdy, tbl[k].rdata);
      @(negedge clk);
      chk_all($sformatf("vec%0d", k), tbl[k].e_stall, tbl[k].e_we, tbl[k].e_addr,
              tbl[k].e_wdata, tbl[k].e_rd, tbl[k].e_cnt, tbl[k].e_fd);
      cyc();
    end

    // Flush with three buffered stores draining at full RAM rate
    drive(1'b1, 32'h40, 32'hA, 1'b0, 1'b0, 32'd0); cyc();
    drive(1'b1, 32'h44, 32'hB, 1'b0, 1'b0, 32'd0); cyc();
    drive(1'b1, 32'h48, 32'hC, 1'b0, 1'b0, 32'd0); cyc();
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd0);
    @(negedge clk);
    chk_all("flush0", 1'b0, 1'b1, 32'h40, 32'hA, 32'd0, 3, 1'b0);
    cyc();
    drive(1'b1, 32'h80, 32'h5, 1'b1, 1'b1, 32'd0);
    @(negedge clk);
    chk_all("flush1", 1'b1, 1'b1, 32'h44, 32'hB, 32'd0, 2, 1'b0);
    cyc();
    @(negedge clk);
    chk_all("flush2", 1'b1, 1'b1, 32'h48, 32'hC, 32'd0, 1, 1'b0);
    cyc();
    @(negedge clk);
    chk_all("flush3", 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 0, 1'b0);
    cyc();
    @(negedge clk);
    chk_all("flush_done", 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 0, 1'b1);
    bus.Flush = 1'b0;
    cyc();
    @(negedge clk);
    chk_all("flush_run", 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 0, 1'b0);
    cyc();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd0);
    @(negedge clk);
    chk_all("flush_post", 1'b0, 1'b1, 32'h80, 32'h5, 32'd0, 1, 1'b0);
    cyc();
    @(negedge clk);
    chk("flush_drained Count", 32'(bus.Count), 32'd0);

    // Asynchronous reset between edges with two stores pending
    cyc();
    drive(1'b1, 32'h200, 32'd1, 1'b0, 1'b0, 32'd0); cyc();
    drive(1'b1, 32'h204, 32'd2, 1'b0, 1'b0, 32'd0); cyc();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("pre_reset Count", 32'(bus.Count), 32'd2);
    reset = 1'b0;
    #2;
    chk_all("async_reset", 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 0, 1'b0);
    #1 reset = 1'b1;
    drive(1'b1, 32'h300, 32'd7, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    chk_all("post_reset", 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 0, 1'b0);
    cyc();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd0);
    @(negedge clk);
    chk_all("first_accept", 1'b0, 1'b1, 32'h300, 32'd7, 32'd0, 1, 1'b0);
    cyc();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("no_stale%0d mem_we", k), 32'(bus.mem_we), 32'd0);
      cyc();
    end

    // Randomized traffic against the queue model
    reset = 1'b0;
    #2 reset = 1'b1;
    q.delete();
    m_mode = 0;
    for (int n = 0; n < 400; n++) begin
      r_mw    = ($urandom_range(0, 9) < 6);
      r_adr   = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
      r_wd    = $urandom;
      r_fl    = ($urandom_range(0, 15) == 0);
      r_rdy   = ($urandom_range(0, 9) < 4);
      r_rdata = $urandom;
      drive(r_mw, r_adr, r_wd, r_fl, r_rdy, r_rdata);
      @(negedge clk);
      sz      = q.size();
      e_stall = r_mw && (sz == DEPTH || m_mode != 0);
      e_we    = (sz > 0);
      e_addr  = e_we ? {q[0].a, 2'b00} : 32'd0;
      e_wdata = e_we ? q[0].d : 32'd0;
      e_rd    = r_rdata;
      for (int i = 0; i < sz; i++) begin
        if (q[i].a == r_adr[31:2]) e_rd = q[i].d;
      end
      chk_all($sformatf("rnd%0d", n), e_stall, e_we, e_addr, e_wdata, e_rd, sz, (m_mode == 2));
      if (sz > 0 && r_rdy) void'(q.pop_front());
      if (r_mw && !e_stall) q.push_back('{a: r_adr[31:2], d: r_wd});
      case (m_mode)
        0:       if (r_fl) m_mode = 1;
        1:       if (sz == 0) m_mode = 2;
        default: m_mode = 0;
      endcase
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
